count_arbiter: RTL and testbench
================================

// Module: count_arbiter
// PURPOSE
//   Shares one CNT_W-bit up-counter datapath between NUM_REQ requesters.
//   Each requester asks for a counting run of its own terminal value.
//   A FSM grants the counter to one requester, runs it from 0 up to that value, pulses done, and releases it.
//   Sits between requester agents (timers, pacing logic) and the counter engine.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   CNT_W    4  counter / terminal-value width in bits
// PORTS
//   clk        in   1                clock, all logic on posedge
//   rst        in   1                synchronous, active-low reset
//   req        in   NUM_REQ          req[i] held high while requester i wants or owns the counter
//   req_max    in   NUM_REQ*CNT_W    terminal value of requester i at bits [i*CNT_W +: CNT_W]
//   grant      out  NUM_REQ          one-hot owner of the counter; all-zero when free
//   active_id  out  $clog2(NUM_REQ)  binary index of owner; 0 when free
//   busy       out  1                counter owned (RUN or DONE state)
//   count      out  CNT_W            current count value
//   done       out  NUM_REQ          one-cycle pulse to owner when its run completes
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=IDLE; grant, active_id, busy, count, done all 0.
//     Round-robin pointer is set so index 0 has first priority. Reset aborts any run silently.
//   - All outputs are registered.
//   - States: IDLE -> RUN -> DONE -> IDLE. A RUN -> IDLE abort path also exists.
//   - IDLE, req!=0: pick winner w and latch max_q <= req_max[w]. Next cycle: RUN, grant[w]=1, busy=1, count=0.
//   - IDLE, req==0: stay in IDLE. count stays 0.
//   - RUN: count increments by 1 per cycle.
//     When count==max_q, next state is DONE. count holds at max_q, done[w]=1, grant held.
//     Run length is max_q+1 RUN cycles, plus 1 DONE cycle.
//   - DONE: lasts exactly 1 cycle. Next state is IDLE with grant=0, busy=0, count=0, done=0.
//   - Abort: req[w]==0 sampled in RUN -> next cycle IDLE, outputs cleared, no done pulse.
//     req[w]==0 in DONE has no effect.
//   - req_max changes after the grant are ignored; only the value latched in IDLE is used.
//   - Arbitration happens only in IDLE, so there is at least 1 free cycle between consecutive grants.
//   - Requester protocol: drop req the cycle after seeing done. If req is still high in IDLE, it counts as a new request.
//   - max_q==0: 1 RUN cycle with count=0, then DONE.
//   - max_q==2^CNT_W-1: count reaches all-ones with no wrap, then DONE.
//   - count never wraps. Arithmetic is CNT_W-bit unsigned.
// CONFIGURATION
//   RR_ARB_EN defined: round-robin arbitration.
//     Search starts at (last granted index + 1) mod NUM_REQ.
//     The pointer updates only on grant.
//   RR_ARB_EN undefined: fixed priority, lowest index wins. No pointer register exists.
// STRUCTURE
//   Package count_arbiter_pkg contains:
//     - typedef enum logic [1:0] {IDLE, RUN, DONE} arb_state_e
//     - localparam defaults for NUM_REQ and CNT_W
//   Sub-module count_engine holds the counter datapath:
//     - inputs clr, en, max; outputs count, at_max
//     - count register, +1 adder, compare to max
//   count_arbiter holds the FSM, the arbiter, and the output registers.
// TESTING
//   1. rst low 2 cycles, then release; req=0
//      -> all outputs 0 and stay 0.
//   2. req[0]=1, max0=3 at cycle T
//      -> grant=0001 at T+1; count 0,1,2,3 over T+1..T+4; done[0] at T+5 only; grant=0 at T+6.
//   3. max1=0
//      -> one RUN cycle with count=0, then done[1].
//   4. max2=15, CNT_W=4
//      -> count reaches 15, done[2], then count 0 and no wrap.
//   5. req[0] and req[2] held high, re-raised after each done
//      -> RR_ARB_EN: grants 0,2,0,2. Without RR_ARB_EN: grants 0,0,0.
//   6. req[1] dropped at count=2
//      -> next cycle grant=0, busy=0, no done.
//   7. rst low at count=5 mid-run
//      -> next cycle all outputs 0. After release, first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/count_arbiter_pkg.sv
// Shared types and default sizes for the count_arbiter slice.
package count_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } arb_state_e;

endpackage

// File: rtl/count_arbiter_if.sv
// Requester-side bus of count_arbiter: requests and terminal values in, grant/count/done out.
interface count_arbiter_if
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_max;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          active_id;
    logic                     busy;
    logic [CNT_W-1:0]         count;
    logic [NUM_REQ-1:0]       done;

    modport master (
        output req, req_max,
        input  grant, active_id, busy, count, done
    );

    modport slave (
        input  req, req_max,
        output grant, active_id, busy, count, done
    );

endinterface

// File: rtl/count_engine.sv
// Shared up-counter datapath: clears, counts up to max and saturates there.
module count_engine
    import count_arbiter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] max,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q, count_d;

    assign at_max = (count_q == max);
    assign count  = count_q;

    always_comb begin
        // NOTE: default assignment first, so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_max) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/count_arbiter.sv
// Grants one shared counter to NUM_REQ requesters and runs it to each owner's terminal value.
// Define RR_ARB_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    count_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   max_q, max_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic               eng_clr, eng_en, at_max;
    logic [CNT_W-1:0]   count;

`ifdef RR_ARB_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Search starts one past the last granted index and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end
`else
    always_comb begin
        win_found = |bus.req;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) win_idx = ID_W'(k);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        active_id_d = active_id_q;
        busy_d      = busy_q;
        max_d       = max_q;
        done_d      = '0;
        eng_clr     = 1'b0;
        eng_en      = 1'b0;
`ifdef RR_ARB_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                eng_clr = 1'b1;
                if (win_found) begin
                    state_d     = RUN;
                    grant_d     = NUM_REQ'(1) << win_idx;
                    active_id_d = win_idx;
                    busy_d      = 1'b1;
                    max_d       = bus.req_max[win_idx*CNT_W +: CNT_W];
`ifdef RR_ARB_EN
                    ptr_d       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`endif
                end
            end
            RUN: begin
                // Owner withdrawing mid-run wins over reaching the terminal value.
                if (!bus.req[active_id_q]) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    active_id_d = '0;
                    busy_d      = 1'b0;
                    eng_clr     = 1'b1;
                end else if (at_max) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else begin
                    eng_en = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                active_id_d = '0;
                busy_d      = 1'b0;
                eng_clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
            max_q       <= '0;
`ifdef RR_ARB_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            active_id_q <= active_id_d;
            busy_q      <= busy_d;
            max_q       <= max_d;
`ifdef RR_ARB_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    count_engine #(.CNT_W(CNT_W)) u_engine (
        .clk    (clk),
        .rst    (rst),
        .clr    (eng_clr),
        .en     (eng_en),
        .max    (max_q),
        .count  (count),
        .at_max (at_max)
    );

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.active_id = active_id_q;
    assign bus.busy      = busy_q;
    assign bus.count     = count;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: stimulus queues expected grant/done events, a monitor checks them.
module tb_count_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic {EV_GRANT, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e           kind;
        logic [NUM_REQ-1:0] vec;
        logic [ID_W-1:0]    id;
        logic [CNT_W-1:0]   cnt;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    count_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    count_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input int id, input int cnt);
        ev_t e;
        e.kind = k;
        e.vec  = NUM_REQ'(1) << id;
        e.id   = ID_W'(id);
        e.cnt  = CNT_W'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic set_max(input int id, input int v);
        bus.req_max[id*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired at time %0t", name, $time);
    endtask

    task automatic wait_done(input int id, input int budget);
        int n = 0;
        while (bus.done[id] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.done[id] !== 1'b1) timeout_fail("done_timeout");
    endtask

    task automatic wait_any_done(input int budget);
        int n = 0;
        while (bus.done === '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.done === '0) timeout_fail("any_done_timeout");
    endtask

    task automatic wait_count(input int id, input int v, input int budget);
        int n = 0;
        while (!(bus.grant[id] === 1'b1 && bus.count === CNT_W'(v)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.grant[id] === 1'b1 && bus.count === CNT_W'(v))) timeout_fail("count_timeout");
    endtask

    // Monitor: pops one expected event per grant rise or done pulse.
    initial begin
        logic [NUM_REQ-1:0] prev_grant;
        ev_t e;
        prev_grant = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind_done", 32'(e.kind), 32'(EV_DONE));
                    check("done_vec", 32'(bus.done), 32'(e.vec));
                    check("done_count", 32'(bus.count), 32'(e.cnt));
                    check("done_grant_held", 32'(bus.grant), 32'(e.vec));
                end
            end
            if (bus.grant != '0 && prev_grant == '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(bus.grant), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind_grant", 32'(e.kind), 32'(EV_GRANT));
                    check("grant_vec", 32'(bus.grant), 32'(e.vec));
                    check("grant_id", 32'(bus.active_id), 32'(e.id));
                    check("grant_count0", 32'(bus.count), 32'(e.cnt));
                    check("grant_busy", 32'(bus.busy), 32'd1);
                end
            end
            prev_grant = bus.grant;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];

        bus.req     = '0;
        bus.req_max = '0;
        rst         = 1'b0;

        // 1: reset, then idle with no requests
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({bus.grant, bus.active_id, bus.busy, bus.count, bus.done}), 32'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_quiet", 32'({bus.grant, bus.active_id, bus.busy, bus.count, bus.done}), 32'd0);
        end

        // 2: requester 0, terminal value 3
        set_max(0, 3);
        push_ev(EV_GRANT, 0, 0);
        push_ev(EV_DONE, 0, 3);
        bus.req[0] = 1'b1;
        @(negedge clk);
        check("t2_grant", 32'(bus.grant), 32'b0001);
        check("t2_count0", 32'(bus.count), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t2_count", 32'(bus.count), 32'(k));
            check("t2_no_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        check("t2_done", 32'(bus.done), 32'b0001);
        check("t2_done_count", 32'(bus.count), 32'd3);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("t2_release", 32'({bus.grant, bus.busy, bus.count, bus.done}), 32'd0);

        // 3: terminal value 0
        set_max(1, 0);
        push_ev(EV_GRANT, 1, 0);
        push_ev(EV_DONE, 1, 0);
        bus.req[1] = 1'b1;
        @(negedge clk);
        check("t3_grant", 32'(bus.grant), 32'b0010);
        @(negedge clk);
        check("t3_done", 32'(bus.done), 32'b0010);
        check("t3_count", 32'(bus.count), 32'd0);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("t3_release", 32'(bus.grant), 32'd0);

        // 4: full-range run; a late req_max change must be ignored
        set_max(2, 15);
        push_ev(EV_GRANT, 2, 0);
        push_ev(EV_DONE, 2, 15);
        bus.req[2] = 1'b1;
        @(negedge clk);
        set_max(2, 3);
        wait_done(2, 40);
        check("t4_count_max", 32'(bus.count), 32'd15);
        bus.req[2] = 1'b0;
        @(negedge clk);
        check("t4_after_count", 32'(bus.count), 32'd0);
        check("t4_after_grant", 32'(bus.grant), 32'd0);

        // 5: requesters 0 and 2 competing
`ifdef RR_ARB_EN
        order = '{0, 2, 0, 2};
`else
        order = '{0, 0, 0};
`endif
        set_max(0, 1);
        set_max(2, 1);
        foreach (order[g]) begin
            push_ev(EV_GRANT, order[g], 0);
            push_ev(EV_DONE, order[g], 1);
        end
        bus.req[0] = 1'b1;
        bus.req[2] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < order.size(); g++) begin
            wait_any_done(20);
            check("t5_winner", 32'(bus.done), 32'(NUM_REQ'(1) << order[g]));
            if (g == order.size() - 1) begin
                bus.req = '0;
            end else begin
                bus.req[order[g]] = 1'b0;
                @(negedge clk);
                bus.req[order[g]] = 1'b1;
            end
        end
        repeat (2) @(negedge clk);

        // 6: owner withdraws at count 2
        set_max(1, 6);
        push_ev(EV_GRANT, 1, 0);
        bus.req[1] = 1'b1;
        wait_count(1, 2, 20);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("t6_abort", 32'({bus.grant, bus.busy, bus.done, bus.count}), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_no_done", 32'(bus.done), 32'd0);

        // 7: reset mid-run at count 5
        set_max(2, 9);
        push_ev(EV_GRANT, 2, 0);
        bus.req[2] = 1'b1;
        wait_count(2, 5, 20);
        rst = 1'b0;
        bus.req = 4'b1010;
        set_max(1, 2);
        set_max(3, 4);
        @(negedge clk);
        check("t7_rst_outputs", 32'({bus.grant, bus.active_id, bus.busy, bus.count, bus.done}), 32'd0);
        @(negedge clk);
        push_ev(EV_GRANT, 1, 0);
        push_ev(EV_DONE, 1, 2);
        rst = 1'b1;
        @(negedge clk);
        check("t7_first_grant", 32'(bus.grant), 32'b0010);
        wait_done(1, 20);
        bus.req = '0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
